// File: rtl/dqn_loss_function.sv
// dqn_loss_function: DQN temporal-difference target, target = reward + GAMMA * q_max,
// or target = reward on a terminal transition. FP32 throughout, two-stage pipeline
// (multiply, then add) with a latched reward/done pair feeding the add stage.
// Optional output clamp to +/-CLIP_VALUE is built when LOSS_CLIP_EN is defined.
module dqn_loss_function #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] GAMMA      = 32'h3F4CCCCD,
   parameter logic [31:0] CLIP_VALUE = 32'h42C80000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_reward_valid,
   input  logic [DATA_WIDTH-1:0] i_reward,
   input  logic                  i_done,
   input  logic                  i_q_max_valid,
   input  logic [DATA_WIDTH-1:0] i_q_max,
   output logic [DATA_WIDTH-1:0] o_loss_value,
   output logic                  o_loss_value_valid
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   // FP32 multiply, round-to-nearest-even, denormals in/out flushed to signed zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [7:0]        ea, eb;
      logic              s, g, st;
      logic [47:0]       p;
      logic [22:0]       m;
      logic [23:0]       mr;
      logic signed [9:0] e;
      ea = a[30:23];
      eb = b[30:23];
      s  = a[31] ^ b[31];
      p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      if (p[47]) begin
         m  = p[46:24];
         g  = p[23];
         st = |p[22:0];
         e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
      end else begin
         m  = p[45:23];
         g  = p[22];
         st = |p[21:0];
         e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      end
      mr = {1'b0, m} + 24'(g & (st | m[0]));
      if (mr[23]) e = e + 10'sd1;
      m = mr[22:0];
      if (ea == 8'hFF || eb == 8'hFF)      fp_mul = QNAN;
      else if (ea == 8'h00 || eb == 8'h00) fp_mul = {s, 31'b0};
      else if (e >= 10'sd255)              fp_mul = {s, 8'hFF, 23'b0};
      else if (e <= 10'sd0)                fp_mul = {s, 31'b0};
      else                                 fp_mul = {s, e[7:0], m};
   endfunction

   // FP32 add with guard/round/sticky alignment and leading-zero renormalisation.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       big, sml;
      logic [7:0]        d;
      logic [26:0]       bm, sx, sm, n, diff;
      logic [27:0]       sum;
      logic [53:0]       ext;
      logic [4:0]        lz;
      logic [23:0]       mr;
      logic signed [9:0] e;
      logic              zero_res;
      fp_add   = '0;
      zero_res = 1'b0;
      n        = '0;
      lz       = '0;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         fp_add = QNAN;
      end else if (a[30:23] == 8'h00) begin
         fp_add = (b[30:23] == 8'h00) ? {b[31], 31'b0} : b;
      end else if (b[30:23] == 8'h00) begin
         fp_add = a;
      end else begin
         if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
         end else begin
            big = b;
            sml = a;
         end
         d  = big[30:23] - sml[30:23];
         bm = {1'b1, big[22:0], 3'b000};
         sx = {1'b1, sml[22:0], 3'b000};
         ext = {sx, 27'b0} >> d;
         // beyond 25 positions the smaller operand only contributes a sticky bit
         if (d >= 8'd26) sm = 27'd1;
         else            sm = ext[53:27] | {26'b0, |ext[26:0]};
         e = $signed({2'b00, big[30:23]});
         if (big[31] == sml[31]) begin
            sum = {1'b0, bm} + {1'b0, sm};
            if (sum[27]) begin
               n = sum[27:1] | {26'b0, sum[0]};
               e = e + 10'sd1;
            end else begin
               n = sum[26:0];
            end
         end else begin
            diff = bm - sm;
            if (diff == '0) begin
               zero_res = 1'b1;
            end else begin
               for (int unsigned i = 0; i < 27; i++) begin
                  if (diff[i]) lz = 5'(26 - i);
               end
               n = diff << lz;
               e = e - $signed({5'b0, lz});
            end
         end
         mr = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
         if (mr[23]) e = e + 10'sd1;
         if (zero_res)            fp_add = '0;
         else if (e >= 10'sd255)  fp_add = {big[31], 8'hFF, 23'b0};
         else if (e <= 10'sd0)    fp_add = {big[31], 31'b0};
         else                     fp_add = {big[31], e[7:0], mr[22:0]};
      end
   endfunction

   // Magnitude clamp to CLIP_VALUE keeping the sign; NaN passes through.
   function automatic logic [31:0] fp_clip(input logic [31:0] x);
      logic is_nan;
      is_nan = (x[30:23] == 8'hFF) && (x[22:0] != '0);
      if (!is_nan && (x[30:0] > CLIP_VALUE[30:0])) fp_clip = {x[31], CLIP_VALUE[30:0]};
      else                                          fp_clip = x;
   endfunction

   logic [31:0] reward_q, prod_q, rew_s1_q, loss_q;
   logic        done_q, done_s1_q, v1_q, valid_q;
   logic [31:0] rew_sel_d, prod_d, loss_d;
   logic        done_sel_d;

   // Reward/done latch, overwritten by every reward strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reward_q <= '0;
         done_q   <= 1'b0;
      end else if (i_reward_valid) begin
         reward_q <= i_reward;
         done_q   <= i_done;
      end
   end

   // Operand selection (same-cycle reward bypasses the latch) and stage-1 product.
   always_comb begin
      rew_sel_d  = i_reward_valid ? i_reward : reward_q;
      done_sel_d = i_reward_valid ? i_done   : done_q;
      prod_d     = fp_mul(GAMMA, i_q_max);
   end

   // Stage 1: product register with reward/done carried alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         prod_q    <= '0;
         rew_s1_q  <= '0;
         done_s1_q <= 1'b0;
      end else begin
         v1_q <= i_q_max_valid;
         if (i_q_max_valid) begin
            prod_q    <= prod_d;
            rew_s1_q  <= rew_sel_d;
            done_s1_q <= done_sel_d;
         end
      end
   end

   // Stage-2 result: terminal transitions pass the reward untouched.
   always_comb begin
      loss_d = done_s1_q ? rew_s1_q : fp_add(rew_s1_q, prod_q);
`ifdef LOSS_CLIP_EN
      loss_d = fp_clip(loss_d);
`endif
   end

   // Stage 2: output register holds the last result; valid is a single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         loss_q  <= '0;
      end else begin
         valid_q <= v1_q;
         if (v1_q) loss_q <= loss_d;
      end
   end

   assign o_loss_value       = loss_q;
   assign o_loss_value_valid = valid_q;

endmodule

// File: tb/tb_dqn_loss_function.sv
// Directed bench for dqn_loss_function with hand-computed FP32 expectations.
// Expectations for the clamp cases follow LOSS_CLIP_EN when it is defined.
module tb_dqn_loss_function;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_reward_valid;
   logic [31:0] i_reward;
   logic        i_done;
   logic        i_q_max_valid;
   logic [31:0] i_q_max;
   logic [31:0] o_loss_value;
   logic        o_loss_value_valid;

   int errors = 0;
   int checks = 0;

   dqn_loss_function #(
      .DATA_WIDTH (32),
      .GAMMA      (32'h3F4CCCCD),
      .CLIP_VALUE (32'h42C80000)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_reward_valid     (i_reward_valid),
      .i_reward           (i_reward),
      .i_done             (i_done),
      .i_q_max_valid      (i_q_max_valid),
      .i_q_max            (i_q_max),
      .o_loss_value       (o_loss_value),
      .o_loss_value_valid (o_loss_value_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_reward(input logic [31:0] r, input logic d);
      i_reward_valid = 1'b1;
      i_reward       = r;
      i_done         = d;
      tick();
      i_reward_valid = 1'b0;
   endtask

   // q_max strobe (optionally with a same-cycle reward), then check the T+2 pulse.
   task automatic run_q(input string tag, input logic rv, input logic [31:0] r, input logic d,
                        input logic [31:0] q, input logic [31:0] exp);
      i_reward_valid = rv;
      i_reward       = r;
      i_done         = d;
      i_q_max_valid  = 1'b1;
      i_q_max        = q;
      tick();
      i_reward_valid = 1'b0;
      i_q_max_valid  = 1'b0;
      chk({tag, "_v_t1"}, 32'(o_loss_value_valid), 32'd0);
      tick();
      chk({tag, "_v_t2"}, 32'(o_loss_value_valid), 32'd1);
      chk({tag, "_data"}, o_loss_value, exp);
      tick();
      chk({tag, "_v_t3"}, 32'(o_loss_value_valid), 32'd0);
      chk({tag, "_hold"}, o_loss_value, exp);
   endtask

   initial begin
      rst_n          = 1'b0;
      i_reward_valid = 1'b0;
      i_reward       = '0;
      i_done         = 1'b0;
      i_q_max_valid  = 1'b0;
      i_q_max        = '0;
      tick();
      tick();
      chk("reset_data", o_loss_value, 32'h0);
      chk("reset_valid", 32'(o_loss_value_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // 1.0 + 0.8*2.0 = 2.6, tie rounded to even
      set_reward(32'h3F800000, 1'b0);
      tick();
      run_q("basic", 1'b0, 32'h0, 1'b0, 32'h40000000, 32'h40266666);

      // terminal transition returns the reward
      set_reward(32'h3F800000, 1'b1);
      run_q("done", 1'b0, 32'h0, 1'b0, 32'h40000000, 32'h3F800000);

      // zero reward, q 1.0 -> 0.8
      set_reward(32'h00000000, 1'b0);
      run_q("zero_rew", 1'b0, 32'h0, 1'b0, 32'h3F800000, 32'h3F4CCCCD);

      // same-cycle reward bypass: -1.0 + 0.8*0 = -1.0
      run_q("bypass", 1'b1, 32'hBF800000, 1'b0, 32'h00000000, 32'hBF800000);

      // back-to-back strobes, latched reward 0
      set_reward(32'h00000000, 1'b0);
      i_q_max_valid = 1'b1;
      i_q_max       = 32'h3F800000;
      tick();
      i_q_max = 32'h40000000;
      chk("b2b_v0", 32'(o_loss_value_valid), 32'd0);
      tick();
      i_q_max = 32'h00000000;
      chk("b2b_v1", 32'(o_loss_value_valid), 32'd1);
      chk("b2b_d1", o_loss_value, 32'h3F4CCCCD);
      tick();
      i_q_max_valid = 1'b0;
      chk("b2b_v2", 32'(o_loss_value_valid), 32'd1);
      chk("b2b_d2", o_loss_value, 32'h3FCCCCCD);
      tick();
      chk("b2b_v3", 32'(o_loss_value_valid), 32'd1);
      chk("b2b_d3", o_loss_value, 32'h00000000);
      tick();
      chk("b2b_v4", 32'(o_loss_value_valid), 32'd0);

      // exact cancellation: -0.8 + 0.8 = +0
      set_reward(32'hBF4CCCCD, 1'b0);
      run_q("cancel", 1'b0, 32'h0, 1'b0, 32'h3F800000, 32'h00000000);

      // denormal q_max treated as zero
      set_reward(32'h3F800000, 1'b0);
      run_q("denorm", 1'b0, 32'h0, 1'b0, 32'h00000001, 32'h3F800000);

      // infinite q_max gives canonical NaN
      run_q("inf_q", 1'b0, 32'h0, 1'b0, 32'h7F800000, 32'h7FC00000);

      // overflow: max + 0.8*max
`ifdef LOSS_CLIP_EN
      run_q("ovf", 1'b1, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 32'h42C80000);
`else
      run_q("ovf", 1'b1, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 32'h7F800000);
`endif

      // clamp boundary cases with terminal reward
`ifdef LOSS_CLIP_EN
      run_q("clip_pos", 1'b1, 32'h43480000, 1'b1, 32'h3F800000, 32'h42C80000);
      run_q("clip_neg", 1'b1, 32'hC3480000, 1'b1, 32'h3F800000, 32'hC2C80000);
`else
      run_q("clip_pos", 1'b1, 32'h43480000, 1'b1, 32'h3F800000, 32'h43480000);
      run_q("clip_neg", 1'b1, 32'hC3480000, 1'b1, 32'h3F800000, 32'hC3480000);
`endif

      // reset one cycle after a strobe: pulse dropped, latch cleared
      set_reward(32'h3F800000, 1'b0);
      i_q_max_valid = 1'b1;
      i_q_max       = 32'h40000000;
      tick();
      i_q_max_valid = 1'b0;
      rst_n         = 1'b0;
      tick();
      chk("rst_v0", 32'(o_loss_value_valid), 32'd0);
      chk("rst_d0", o_loss_value, 32'h0);
      rst_n = 1'b1;
      tick();
      chk("rst_v1", 32'(o_loss_value_valid), 32'd0);
      chk("rst_d1", o_loss_value, 32'h0);
      tick();
      chk("rst_v2", 32'(o_loss_value_valid), 32'd0);
      run_q("post_rst", 1'b0, 32'h0, 1'b0, 32'h3F800000, 32'h3F4CCCCD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dqn_loss_function.md
Name: dqn_loss_function

Overview:
- Computes the DQN temporal-difference target for one transition: target = reward + GAMMA * q_max, or target = reward when the episode is done.
- Sits between the target network (supplies q_max) and the main network (consumes the target as its "loss value" for backpropagation on the taken action).
- All data is IEEE-754 single precision (FP32).

Parameters:
- DATA_WIDTH, 32: data word width; only 32 (FP32) is supported.
- GAMMA, 'h3F4CCCCD (0.8): discount factor, FP32 bit pattern.
- CLIP_VALUE, 'h42C80000 (100.0): positive FP32 clip magnitude; used only when LOSS_CLIP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_reward_valid  in  1  one-cycle strobe; captures i_reward and i_done.
- i_reward  in  DATA_WIDTH  FP32 reward of the transition.
- i_done  in  1  terminal-transition flag, sampled with i_reward_valid.
- i_q_max_valid  in  1  one-cycle strobe; i_q_max is valid.
- i_q_max  in  DATA_WIDTH  FP32 max Q over next-state actions.
- o_loss_value  out  DATA_WIDTH  FP32 TD target.
- o_loss_value_valid  out  1  one-cycle strobe; o_loss_value is valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All registers clear.
  - o_loss_value=0 and o_loss_value_valid=0.
  - Latched reward = 0 and latched done = 0.
  - In-flight pipeline valids are dropped; no output pulse follows reset.
- Capture:
  - When i_reward_valid=1, the reward and done registers load i_reward and i_done.
  - They hold until the next i_reward_valid.
  - A new strobe overwrites any pending value.
- Computation starts when i_q_max_valid=1 (cycle T).
  - Operand selection: if i_reward_valid is also high in cycle T, the incoming i_reward/i_done are used (bypass). Otherwise the latched values are used.
  - Stage 1, registered at T+1: product = GAMMA * i_q_max (FP32 multiply). Reward and done are carried along with the product.
  - Stage 2, registered at T+2: if done=1, result = reward unchanged; else result = reward + product (FP32 add).
  - o_loss_value_valid pulses high for exactly one cycle at T+2.
  - o_loss_value updates in that same cycle and holds its value until the next result.
- Throughput:
  - Fully pipelined; a new i_q_max_valid may arrive every cycle.
  - Each input strobe yields exactly one output strobe, 2 cycles later, in order.
- i_q_max_valid with no prior reward captured uses reward = +0.0.
- FP32 arithmetic rules:
  - Rounding: round-to-nearest-even for both the multiply and the add.
  - Denormal inputs are treated as signed zero.
  - Results below the normal range flush to signed zero.
  - Exponent overflow gives signed infinity (exp=255, mantissa=0).
  - Infinity or NaN operands give canonical NaN 'h7FC00000.
  - Zero operands: x*0 = signed zero; x+0 = x.
  - Exact cancellation (a + (-a)) gives +0.0.
  - Addition: align by exponent difference, using guard/round/sticky bits. A shift of 26 or more makes the smaller operand sticky-only. Renormalize with leading-zero count after subtraction.

Optional Feature:
- Macro LOSS_CLIP_EN.
- Defined: before registering at stage 2, the result is clamped to [-CLIP_VALUE, +CLIP_VALUE].
  - The compare is magnitude-based on exponent/mantissa.
  - A clipped result keeps its sign with magnitude CLIP_VALUE.
  - NaN passes through unchanged.
  - Latency stays 2 cycles.
- Not defined: no clamping; the stage-2 result is output directly.

Test Plan:
- Reset, then i_reward_valid with reward='h3F800000 (1.0), done=0; two cycles later i_q_max_valid with q_max='h40000000 (2.0) -> o_loss_value_valid pulses 2 cycles later with o_loss_value='h40266666 (2.6, tie rounded to even).
- Reward 'h3F800000, done=1; q_max 'h40000000 -> output 'h3F800000, valid one pulse at T+2.
- Reward 'h00000000, done=0; q_max 'h3F800000 -> output 'h3F4CCCCD (0.8). Same cycle strobes of reward 'hBF800000 (-1.0) and q_max 'h00000000 -> output 'hBF800000 (bypass of the new reward).
- Back-to-back i_q_max_valid on three consecutive cycles with q_max 1.0, 2.0, 0.0 and latched reward 0 -> three consecutive output pulses 'h3F4CCCCD, 'h3FCCCCCD, 'h00000000 at T+2..T+4.
- Assert rst_n=0 one cycle after i_q_max_valid -> no o_loss_value_valid pulse; output reads 0; latched reward cleared.
- With LOSS_CLIP_EN: reward 'h43480000 (200.0), done=1 -> output 'h42C80000; reward 'hC3480000 -> 'hC2C80000. Without the macro, the same stimulus outputs 'h43480000 and 'hC3480000 respectively.
